// File: rtl/fir_filter.sv
// 4-tap direct-form FIR filter with compile-time coefficients.
// Each accepted sample shifts the delay line; output is registered.
module fir_filter #(
    parameter logic signed [7:0] COEF0 = 8'sd1,
    parameter logic signed [7:0] COEF1 = 8'sd2,
    parameter logic signed [7:0] COEF2 = 8'sd3,
    parameter logic signed [7:0] COEF3 = 8'sd4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_en,
    input  logic signed [7:0]  data,
    output logic signed [17:0] result,
    output logic               result_valid
);

    // 16-bit copies so each 16x16 product is exact and signed.
    localparam logic signed [15:0] C0 = 16'(COEF0);
    localparam logic signed [15:0] C1 = 16'(COEF1);
    localparam logic signed [15:0] C2 = 16'(COEF2);
    localparam logic signed [15:0] C3 = 16'(COEF3);

    logic signed [7:0]  x1_q, x1_d;
    logic signed [7:0]  x2_q, x2_d;
    logic signed [7:0]  x3_q, x3_d;
    logic signed [17:0] result_q, result_d;
    logic               valid_q, valid_d;

    logic signed [15:0] p0, p1, p2, p3;
    logic signed [17:0] sum;

    // Tap products and exact 18-bit sum over the pre-edge delay line.
    always_comb begin
        p0  = C0 * 16'(data);
        p1  = C1 * 16'(x1_q);
        p2  = C2 * 16'(x2_q);
        p3  = C3 * 16'(x3_q);
        sum = 18'(p0) + 18'(p1) + 18'(p2) + 18'(p3);
    end

    // Next state: only accepted samples advance the line and output.
    always_comb begin
        x1_d     = x1_q;
        x2_d     = x2_q;
        x3_d     = x3_q;
        result_d = result_q;
        valid_d  = 1'b0;
        if (data_en) begin
            x1_d     = data;
            x2_d     = x1_q;
            x3_d     = x2_q;
            result_d = sum;
            valid_d  = 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q     <= '0;
            x2_q     <= '0;
            x3_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            x3_q     <= x3_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: default taps plus an all -128 instance.
// Stimulus pushes expected outputs; negedge monitors pop and compare.
module tb_fir_filter;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en1 = 1'b0, en2 = 1'b0;
    logic signed [7:0]  d1 = '0, d2 = '0;
    logic signed [17:0] r1, r2;
    logic               v1, v2;

    logic signed [17:0] q1[$];
    logic signed [17:0] q2[$];
    logic signed [17:0] hold1 = '0, hold2 = '0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_filter u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_en(en1), .data(d1),
        .result(r1), .result_valid(v1)
    );

    fir_filter #(
        .COEF0(-8'sd128), .COEF1(-8'sd128),
        .COEF2(-8'sd128), .COEF3(-8'sd128)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data_en(en2), .data(d2),
        .result(r2), .result_valid(v2)
    );

    // Held-value tracking restarts from zero whenever reset asserts.
    always @(negedge rst_n) begin
        hold1 = '0;
        hold2 = '0;
    end

    // Monitor for the default-coefficient instance.
    always @(negedge clk) begin
        logic signed [17:0] e;
        n_cmp++;
        if (v1) begin
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL dut1_unexpected_valid result=%0d", r1);
            end else begin
                e = q1.pop_front();
                if (r1 !== e) begin
                    n_err++;
                    $display("FAIL dut1_result got=%0d exp=%0d", r1, e);
                end
                hold1 = e;
            end
        end else if (r1 !== hold1) begin
            n_err++;
            $display("FAIL dut1_hold got=%0d exp=%0d", r1, hold1);
        end
    end

    // Monitor for the all -128 instance.
    always @(negedge clk) begin
        logic signed [17:0] e;
        n_cmp++;
        if (v2) begin
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL dut2_unexpected_valid result=%0d", r2);
            end else begin
                e = q2.pop_front();
                if (r2 !== e) begin
                    n_err++;
                    $display("FAIL dut2_result got=%0d exp=%0d", r2, e);
                end
                hold2 = e;
            end
        end else if (r2 !== hold2) begin
            n_err++;
            $display("FAIL dut2_hold got=%0d exp=%0d", r2, hold2);
        end
    end

    // One cycle of dut1 stimulus; exp is pushed when a sample is offered.
    task automatic s1(input bit en, input logic signed [7:0] d,
                      input int exp);
        @(posedge clk);
        #1;
        en1 = en;
        d1  = d;
        en2 = 1'b0;
        if (en) q1.push_back(18'(exp));
    endtask

    task automatic s2(input bit en, input logic signed [7:0] d,
                      input int exp);
        @(posedge clk);
        #1;
        en2 = en;
        d2  = d;
        en1 = 1'b0;
        if (en) q2.push_back(18'(exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) s1(1'b0, 8'sd0, 0);
    endtask

    // Synchronous-looking reset: assert mid-cycle, release after 2 edges.
    task automatic do_reset();
        @(posedge clk);
        #1;
        en1   = 1'b0;
        en2   = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (r1 !== 18'sd0 || v1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clear got=%0d/%0b exp=0/0", r1, v1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held while strobes with data=100 are presented.
        repeat (2) @(posedge clk);
        #1;
        en1 = 1'b1; d1 = 8'sd100;
        en2 = 1'b1; d2 = 8'sd100;
        repeat (3) @(posedge clk);
        #1;
        en1 = 1'b0; en2 = 1'b0;
        rst_n = 1'b1;
        s1(1'b1, 8'sd5, 5);
        idle(3);

        // Isolated strobes every 10 clocks.
        do_reset();
        s1(1'b1, 8'sd23, 23);  idle(9);
        s1(1'b1, 8'sd1,  47);  idle(9);
        s1(1'b1, 8'sd45, 116); idle(9);
        s1(1'b1, 8'sd11, 196); idle(9);
        s1(1'b1, 8'sd20, 181); idle(9);

        // Impulse response with continuous enable.
        do_reset();
        s1(1'b1, 8'sd1, 1);
        s1(1'b1, 8'sd0, 2);
        s1(1'b1, 8'sd0, 3);
        s1(1'b1, 8'sd0, 4);
        s1(1'b1, 8'sd0, 0);
        idle(3);

        // Extremes on the all -128 instance.
        do_reset();
        s2(1'b1, -8'sd128, 16384);
        s2(1'b1, -8'sd128, 32768);
        s2(1'b1, -8'sd128, 49152);
        s2(1'b1, -8'sd128, 65536);
        s2(1'b1, 8'sd127, 32896);
        s2(1'b1, 8'sd127, 256);
        s2(1'b1, 8'sd127, -32384);
        s2(1'b1, 8'sd127, -65024);
        s2(1'b0, 8'sd0, 0);
        idle(3);

        // Long idle gap with toggling data that must be ignored.
        do_reset();
        s1(1'b1, 8'sd10, 10);
        for (int i = 0; i < 50; i++)
            s1(1'b0, 8'($urandom), 0);
        s1(1'b1, 8'sd0, 20);
        idle(3);

        // Mid-stream asynchronous reset between clock edges.
        do_reset();
        s1(1'b1, 8'sd7, 7);
        s1(1'b1, 8'sd8, 22);
        idle(2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (r1 !== 18'sd0 || v1 !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got=%0d/%0b exp=0/0", r1, v1);
        end
        #1;
        rst_n = 1'b1;
        s1(1'b1, 8'sd9, 9);
        idle(3);

        // All expected outputs must have been consumed.
        repeat (3) @(posedge clk);
        n_cmp++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d/%0d exp=0/0",
                     q1.size(), q2.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_err);
        $finish;
    end

endmodule
